// File: rtl/enc_tx_scheduler_pkg.sv
// Shared types and constants for the encrypting transmit scheduler.
// Holds the FSM encoding, LFSR taps and frame geometry.
package enc_tx_scheduler_pkg;

  localparam int NIB_W   = 4;
  localparam int MAX_NIB = 16;
  localparam int LFSR_W  = 8;

  // Fibonacci taps 8,6,5,4 map to state bits 0,2,3,4 when shifting toward bit 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DONE,
    ABORT
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/enc_tx_scheduler_if.sv
// Requester, buffer and status signals of the transmit scheduler.
// The requester/buffer side uses master, the scheduler uses slave.
interface enc_tx_scheduler_if;
  import enc_tx_scheduler_pkg::*;

  logic [1:0]       s_valid;
  logic [NIB_W-1:0] s_data0;
  logic [NIB_W-1:0] s_data1;
  logic [1:0]       s_last;
  logic [1:0]       s_ready;
  logic             buf_ena;
  logic [3:0]       buf_addr;
  logic [NIB_W-1:0] buf_data;
  logic             buf_ena_out;
  logic             key;
  logic             busy;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic [1:0]       err;

  modport master (
    output s_valid, s_data0, s_data1, s_last, buf_ena_out,
    input  s_ready, buf_ena, buf_addr, buf_data, key, busy, grant, done, err
  );

  modport slave (
    input  s_valid, s_data0, s_data1, s_last, buf_ena_out,
    output s_ready, buf_ena, buf_addr, buf_data, key, busy, grant, done, err
  );

endinterface

// File: rtl/enc_keystream_lfsr.sv
// Keystream generator: 8-bit Fibonacci LFSR, reloadable per frame.
// key is a register so it holds its value between steps.
module enc_keystream_lfsr
  import enc_tx_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic              key
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;

  always_comb begin
    lfsr_nxt = lfsr;
    if (load)      lfsr_nxt = seed;
    else if (step) lfsr_nxt = lfsr_step(lfsr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      key  <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      if (load || step) key <= lfsr_nxt[0];
    end
  end

endmodule

// File: rtl/enc_tx_scheduler.sv
// Round-robin scheduler: loads a nibble frame into the buffer, counts the
// emitted serial bits and drives the XOR keystream for the owning requester.
module enc_tx_scheduler
  import enc_tx_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  parameter int                TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst_n,
  enc_tx_scheduler_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic       g_idx;
  logic       ptr;
  logic       pick;
  logic       req_any;
  logic       xfer;
  logic       last_nib;
  logic       strobe;
  logic [3:0] nib_cnt;
  logic [6:0] bit_cnt;
  logic [6:0] bit_cnt_inc;
  logic [6:0] bit_target;
  logic [7:0] idle_cnt;
  logic [1:0] grant_q;
  logic [1:0] done_q;
  logic [1:0] err_q;
  logic       busy_q;

  assign req_any     = |bus.s_valid;
  assign pick        = bus.s_valid[ptr] ? ptr : ~ptr;
  assign xfer        = (state == LOAD) && bus.s_valid[g_idx];
  assign last_nib    = bus.s_last[g_idx] || (nib_cnt == 4'(MAX_NIB - 1));
  assign strobe      = (state == SEND) && bus.buf_ena_out;
  assign bit_cnt_inc = bit_cnt + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Buffer write port follows the handshake directly so the first nibble lands in the first LOAD cycle
  always_comb begin
    state_nxt    = state;
    bus.s_ready  = 2'b00;
    bus.buf_ena  = 1'b0;
    bus.buf_addr = 4'd0;
    bus.buf_data = '0;
    case (state)
      IDLE: if (req_any) state_nxt = LOAD;
      LOAD: begin
        bus.s_ready = grant_q;
        if (xfer) begin
          bus.buf_ena  = 1'b1;
          bus.buf_addr = nib_cnt;
          bus.buf_data = g_idx ? bus.s_data1 : bus.s_data0;
          if (last_nib) state_nxt = SEND;
        end
      end
      SEND: begin
        // A strobe always wins over the timeout on the same cycle
        if (strobe) begin
          if (bit_cnt_inc == bit_target) state_nxt = DONE;
        end else if (idle_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = ABORT;
        end
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_idx      <= 1'b0;
      ptr        <= 1'b0;
      nib_cnt    <= 4'd0;
      bit_cnt    <= 7'd0;
      bit_target <= 7'd0;
      idle_cnt   <= 8'd0;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE)  ? grant_q : 2'b00;
      err_q  <= (state_nxt == ABORT) ? grant_q : 2'b00;
      case (state)
        IDLE: begin
          if (req_any) begin
            g_idx   <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
          end
          nib_cnt  <= 4'd0;
          bit_cnt  <= 7'd0;
          idle_cnt <= 8'd0;
        end
        LOAD: begin
          if (xfer) begin
            nib_cnt <= nib_cnt + 4'd1;
            if (last_nib) bit_target <= {5'({1'b0, nib_cnt}) + 5'd1, 2'b00};
          end
        end
        SEND: begin
          if (strobe) begin
            bit_cnt  <= bit_cnt_inc;
            idle_cnt <= 8'd0;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        DONE, ABORT: begin
          ptr     <= ~g_idx;
          grant_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

  enc_keystream_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load ((state == IDLE) && req_any),
    .step (strobe),
    .seed (LFSR_SEED ^ {7'b0, pick}),
    .key  (bus.key)
  );

endmodule

// File: tb/tb_enc_tx_scheduler.sv
// Directed bench for enc_tx_scheduler: frame load, keystream, arbitration,
// frame-length limit, timeout, asynchronous reset and idle strobes.
module tb_enc_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_lfsr;

  enc_tx_scheduler_if bus ();

  enc_tx_scheduler #(
    .LFSR_SEED(8'hA5),
    .TIMEOUT  (255)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference keystream: x^8+x^6+x^5+x^4+1, shifting toward bit 0
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  task automatic idle_inputs();
    bus.s_valid     = 2'b00;
    bus.s_data0     = 4'h0;
    bus.s_data1     = 4'h0;
    bus.s_last      = 2'b00;
    bus.buf_ena_out = 1'b0;
  endtask

  task automatic drive(input logic [1:0] vmask, input int req, input logic [3:0] v, input bit l);
    bus.s_valid = vmask;
    bus.s_data0 = (req == 0) ? v : ~v;
    bus.s_data1 = (req == 1) ? v : ~v;
    bus.s_last  = l ? ((req == 1) ? 2'b10 : 2'b01) : 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_frame(input logic [1:0] vmask, input int req, input int n,
                            input bit set_last, input logic [3:0] base);
    logic [1:0] g;
    logic [3:0] v;
    g = (req == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(vmask, req, base, set_last && (n == 1));
    #1;
    total++;
    if (bus.s_ready !== 2'b00) begin
      bad++;
      $display("FAIL idle_s_ready got=%b want=00", bus.s_ready);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v = base + 4'(i);
      drive(vmask, req, v, set_last && (i == n - 1));
      #1;
      total++;
      if (bus.grant !== g || bus.s_ready !== g || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL load_grant i=%0d grant=%b s_ready=%b busy=%b want=%b", i, bus.grant, bus.s_ready, bus.busy, g);
      end
      total++;
      if (bus.buf_ena !== 1'b1 || bus.buf_addr !== 4'(i) || bus.buf_data !== v) begin
        bad++;
        $display("FAIL buf_write i=%0d ena=%b addr=%h data=%h want ena=1 addr=%h data=%h",
                 i, bus.buf_ena, bus.buf_addr, bus.buf_data, 4'(i), v);
      end
    end
    // One more nibble offered: the frame is closed and must not take it
    @(negedge clk);
    drive(vmask, req, base + 4'(n), 1'b0);
    #1;
    total++;
    if (bus.s_ready !== 2'b00 || bus.buf_ena !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL send_entry s_ready=%b buf_ena=%b busy=%b want 00/0/1", bus.s_ready, bus.buf_ena, bus.busy);
    end
    bus.s_valid = 2'b00;
    bus.s_last  = 2'b00;
  endtask

  task automatic send_bits(input int req, input int nbits);
    logic [1:0] g;
    g = (req == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.buf_ena_out = 1'b1;
      #1;
      total++;
      if (bus.key !== exp_lfsr[0] || bus.done !== 2'b00) begin
        bad++;
        $display("FAIL key_bit i=%0d key=%b done=%b want key=%b done=00", i, bus.key, bus.done, exp_lfsr[0]);
      end
      exp_lfsr = ref_next(exp_lfsr);
    end
    @(negedge clk);
    bus.buf_ena_out = 1'b0;
    #1;
    total++;
    if (bus.done !== g || bus.err !== 2'b00 || bus.key !== exp_lfsr[0]) begin
      bad++;
      $display("FAIL done_pulse done=%b err=%b key=%b want done=%b err=00 key=%b", bus.done, bus.err, bus.key, g, exp_lfsr[0]);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.done !== 2'b00 || bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL after_done done=%b busy=%b grant=%b want 00/0/00", bus.done, bus.busy, bus.grant);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.err !== 2'b00 ||
        bus.key !== 1'b0 || bus.s_ready !== 2'b00 || bus.buf_ena !== 1'b0 ||
        bus.buf_addr !== 4'h0 || bus.buf_data !== 4'h0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b grant=%b done=%b err=%b key=%b s_ready=%b buf_ena=%b want all 0",
               bus.busy, bus.grant, bus.done, bus.err, bus.key, bus.s_ready, bus.buf_ena);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b grant=%b want 0/00", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single_frame();
    load_frame(2'b01, 0, 3, 1'b1, 4'h1);
    exp_lfsr = 8'hA5;
    send_bits(0, 12);
  endtask

  task automatic test_arbitration();
    do_reset();
    load_frame(2'b11, 0, 1, 1'b1, 4'h7);
    exp_lfsr = 8'hA5;
    send_bits(0, 4);
    load_frame(2'b11, 1, 1, 1'b1, 4'h8);
    exp_lfsr = 8'hA4;
    send_bits(1, 4);
    load_frame(2'b11, 0, 2, 1'b1, 4'hA);
    exp_lfsr = 8'hA5;
    send_bits(0, 8);
  endtask

  task automatic test_max_frame();
    load_frame(2'b10, 1, 16, 1'b0, 4'h0);
    exp_lfsr = 8'hA4;
    send_bits(1, 64);
  endtask

  task automatic test_timeout();
    load_frame(2'b10, 1, 2, 1'b1, 4'h5);
    for (int c = 2; c <= 255; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.err !== 2'b00 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL timeout_wait c=%0d err=%b busy=%b want 00/1", c, bus.err, bus.busy);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.err !== 2'b10 || bus.done !== 2'b00) begin
      bad++;
      $display("FAIL timeout_err err=%b done=%b want 10/00", bus.err, bus.done);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.err !== 2'b00 || bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
      bad++;
      $display("FAIL after_abort err=%b busy=%b grant=%b want 00/0/00", bus.err, bus.busy, bus.grant);
    end
  endtask

  task automatic test_timeout_edge();
    load_frame(2'b01, 0, 1, 1'b1, 4'hC);
    exp_lfsr = 8'hA5;
    repeat (253) @(negedge clk);
    @(negedge clk);
    bus.buf_ena_out = 1'b1;
    #1;
    total++;
    if (bus.key !== exp_lfsr[0] || bus.err !== 2'b00) begin
      bad++;
      $display("FAIL edge_strobe key=%b err=%b want %b/00", bus.key, bus.err, exp_lfsr[0]);
    end
    exp_lfsr = ref_next(exp_lfsr);
    @(negedge clk);
    bus.buf_ena_out = 1'b0;
    #1;
    total++;
    if (bus.err !== 2'b00 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL edge_no_abort err=%b busy=%b want 00/1", bus.err, bus.busy);
    end
    send_bits(0, 3);
  endtask

  task automatic test_reset_mid_send();
    load_frame(2'b01, 0, 2, 1'b1, 4'h3);
    exp_lfsr = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.buf_ena_out = 1'b1;
      #1;
      total++;
      if (bus.key !== exp_lfsr[0]) begin
        bad++;
        $display("FAIL pre_reset_key i=%0d key=%b want %b", i, bus.key, exp_lfsr[0]);
      end
      exp_lfsr = ref_next(exp_lfsr);
    end
    @(negedge clk);
    bus.buf_ena_out = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.err !== 2'b00 || bus.key !== 1'b0) begin
      bad++;
      $display("FAIL async_reset busy=%b grant=%b done=%b err=%b key=%b want all 0",
               bus.busy, bus.grant, bus.done, bus.err, bus.key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.done !== 2'b00 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset done=%b busy=%b want 00/0", bus.done, bus.busy);
    end
    load_frame(2'b01, 0, 1, 1'b1, 4'h9);
    exp_lfsr = 8'hA5;
    send_bits(0, 4);
  endtask

  task automatic test_idle_strobe();
    logic k;
    k = exp_lfsr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.buf_ena_out = 1'b1;
      #1;
      total++;
      if (bus.key !== k || bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
        bad++;
        $display("FAIL idle_strobe i=%0d key=%b busy=%b grant=%b want %b/0/00", i, bus.key, bus.busy, bus.grant, k);
      end
    end
    @(negedge clk);
    bus.buf_ena_out = 1'b0;
    #1;
    total++;
    if (bus.key !== k || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold key=%b busy=%b want %b/0", bus.key, bus.busy, k);
    end
    load_frame(2'b01, 0, 1, 1'b1, 4'hE);
    exp_lfsr = 8'hA5;
    send_bits(0, 4);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_arbitration();
    test_max_frame();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_send();
    test_idle_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
